// File: rtl/cpu_16_pkg.sv
// Shared definitions for the cpu_16 core: opcodes, ALU functions, FSM states,
// the HALT encoding and the instruction field decoder.
package cpu_16_pkg;

   localparam int DATA_W = 16;

   // Opcodes, ir[15:12]
   localparam logic [3:0] OP_ALU  = 4'h0;
   localparam logic [3:0] OP_ADDI = 4'h1;
   localparam logic [3:0] OP_MOVI = 4'h2;
   localparam logic [3:0] OP_MHI  = 4'h3;
   localparam logic [3:0] OP_LW   = 4'h4;
   localparam logic [3:0] OP_SW   = 4'h5;
   localparam logic [3:0] OP_BZ   = 4'h6;
   localparam logic [3:0] OP_BNZ  = 4'h7;
   localparam logic [3:0] OP_B    = 4'h8;
   localparam logic [3:0] OP_JR   = 4'h9;

   // ALU functions, ir[2:0] when op == OP_ALU
   localparam logic [2:0] FN_ADD = 3'd0;
   localparam logic [2:0] FN_SUB = 3'd1;
   localparam logic [2:0] FN_AND = 3'd2;
   localparam logic [2:0] FN_OR  = 3'd3;
   localparam logic [2:0] FN_XOR = 3'd4;
   localparam logic [2:0] FN_SLL = 3'd5;
   localparam logic [2:0] FN_SRL = 3'd6;
   localparam logic [2:0] FN_SRA = 3'd7;

   localparam logic [15:0] HALT_INSN = 16'hFFFF;

   typedef enum logic [2:0] {
      FETCH = 3'd0,
      FWAIT = 3'd1,
      EXEC  = 3'd2,
      LWAIT = 3'd3,
      SWAIT = 3'd4,
      HALT  = 3'd5
   } state_e;

   typedef struct packed {
      logic [3:0]  op;
      logic [2:0]  rd;
      logic [2:0]  ra;
      logic [2:0]  rb;
      logic [2:0]  fn;
      logic [15:0] imm6;
      logic [15:0] imm9;
      logic [15:0] imm12;
   } dec_t;

   // Split an instruction word into its fields, immediates sign-extended.
   function automatic dec_t decode(input logic [15:0] ir);
      dec_t d;
      d.op    = ir[15:12];
      d.rd    = ir[11:9];
      d.ra    = ir[8:6];
      d.rb    = ir[5:3];
      d.fn    = ir[2:0];
      d.imm6  = {{10{ir[5]}}, ir[5:0]};
      d.imm9  = {{7{ir[8]}}, ir[8:0]};
      d.imm12 = {{4{ir[11]}}, ir[11:0]};
      return d;
   endfunction

   // Register-register ALU; shifts use only the low four bits of b.
   function automatic logic [15:0] alu(input logic [2:0] fn,
                                       input logic [15:0] a,
                                       input logic [15:0] b);
      logic [15:0] r;
      case (fn)
         FN_ADD:  r = a + b;
         FN_SUB:  r = a - b;
         FN_AND:  r = a & b;
         FN_OR:   r = a | b;
         FN_XOR:  r = a ^ b;
         FN_SLL:  r = a << b[3:0];
         FN_SRL:  r = a >> b[3:0];
         FN_SRA:  r = $unsigned($signed(a) >>> b[3:0]);
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/cpu_16_regfile.sv
// Eight-entry register file: three combinational read ports, one write port
// updated at the clock edge. Contents are deliberately not reset.
module regfile
   import cpu_16_pkg::*;
(
   input  logic              clk,
   input  logic              we_i,
   input  logic [2:0]        waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [2:0]        raddr_a_i,
   input  logic [2:0]        raddr_b_i,
   input  logic [2:0]        raddr_d_i,
   output logic [DATA_W-1:0] rdata_a_o,
   output logic [DATA_W-1:0] rdata_b_o,
   output logic [DATA_W-1:0] rdata_d_o
);

   logic [DATA_W-1:0] rmem [0:7];

   // Single write per cycle, no reset so software must initialise registers.
   always_ff @(posedge clk) begin
      if (we_i) begin
         rmem[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = rmem[raddr_a_i];
   assign rdata_b_o = rmem[raddr_b_i];
   assign rdata_d_o = rmem[raddr_d_i];

endmodule

// File: rtl/cpu_16.sv
// cpu_16: multi-cycle 16-bit CPU with separate instruction and data ports.
// Each instruction walks FETCH -> FWAIT -> EXEC, with LWAIT/SWAIT added for
// loads and stores. HALT (ir == 16'hFFFF) parks the core until reset.
//
// Memory handshake: a *_req output is a one-cycle pulse launching a single
// transfer; the address (and store data) stay constant from that pulse until
// the matching *_rdy is sampled high in the owning wait state. rdy is a
// one-cycle completion strobe and is ignored in every other state.
module cpu_16
   import cpu_16_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] ins_rd_addr,
   input  logic [15:0] ins_rd_data,
   output logic        ins_rd_req,
   input  logic        ins_rd_rdy,
   output logic [15:0] dat_rw_addr,
   input  logic [15:0] dat_rd_data,
   output logic        dat_rd_req,
   input  logic        dat_rd_rdy,
   output logic [15:0] dat_wr_data,
   output logic        dat_wr_req,
   input  logic        dat_wr_rdy
);

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] ir_q, ir_d;
   logic [15:0] dat_addr_q, dat_addr_d;
   logic [15:0] dat_wdata_q, dat_wdata_d;
   logic        dat_rd_req_q, dat_rd_req_d;
   logic        dat_wr_req_q, dat_wr_req_d;

   dec_t        dec;
   logic        is_halt;
   logic [15:0] pc_inc;
   logic [15:0] ea;
   logic [15:0] ra_val, rb_val, rd_val;

   logic        exec_we;
   logic [15:0] exec_wdata;
   logic [15:0] exec_pc;

   logic        fetch_req;
   logic        rf_we;
   logic [15:0] rf_wdata;

   assign dec     = decode(ir_q);
   assign is_halt = (ir_q == HALT_INSN);
   assign pc_inc  = pc_q + 16'd1;
   assign ea      = ra_val + dec.imm6;

   regfile regs (
      .clk       (clk),
      .we_i      (rf_we & reset),
      .waddr_i   (dec.rd),
      .wdata_i   (rf_wdata),
      .raddr_a_i (dec.ra),
      .raddr_b_i (dec.rb),
      .raddr_d_i (dec.rd),
      .rdata_a_o (ra_val),
      .rdata_b_o (rb_val),
      .rdata_d_o (rd_val)
   );

   // Result and next pc of a non-memory instruction in EXEC.
   always_comb begin
      exec_we    = 1'b0;
      exec_wdata = '0;
      exec_pc    = pc_inc;
      case (dec.op)
         OP_ALU: begin
            exec_we    = 1'b1;
            exec_wdata = alu(dec.fn, ra_val, rb_val);
         end
         OP_ADDI: begin
            exec_we    = 1'b1;
            exec_wdata = ra_val + dec.imm6;
         end
         OP_MOVI: begin
            exec_we    = 1'b1;
            exec_wdata = dec.imm9;
         end
         OP_MHI: begin
            exec_we    = 1'b1;
            exec_wdata = {ir_q[7:0], rd_val[7:0]};
         end
         OP_BZ: begin
            if (rd_val == 16'd0) exec_pc = pc_inc + dec.imm9;
         end
         OP_BNZ: begin
            if (rd_val != 16'd0) exec_pc = pc_inc + dec.imm9;
         end
         OP_B: begin
            exec_pc = pc_inc + dec.imm12;
         end
         OP_JR: begin
            exec_pc = ra_val;
         end
         default: ;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH: state_d = FWAIT;
         FWAIT: if (ins_rd_rdy) state_d = EXEC;
         EXEC: begin
            if (is_halt)               state_d = HALT;
            else if (dec.op == OP_LW)  state_d = LWAIT;
            else if (dec.op == OP_SW)  state_d = SWAIT;
            else                       state_d = FETCH;
         end
         LWAIT: if (dat_rd_rdy) state_d = FETCH;
         SWAIT: if (dat_wr_rdy) state_d = FETCH;
         HALT:  state_d = HALT;
         default: state_d = FETCH;
      endcase
   end

   // FSM outputs: fetch request, write-back, pc/ir updates, data requests.
   // Data requests are registered out of EXEC, so they pulse in the first
   // cycle of LWAIT/SWAIT together with the registered address and data.
   always_comb begin
      fetch_req    = 1'b0;
      rf_we        = 1'b0;
      rf_wdata     = exec_wdata;
      ir_d         = ir_q;
      pc_d         = pc_q;
      dat_rd_req_d = 1'b0;
      dat_wr_req_d = 1'b0;
      dat_addr_d   = dat_addr_q;
      dat_wdata_d  = dat_wdata_q;
      case (state_q)
         FETCH: fetch_req = 1'b1;
         FWAIT: if (ins_rd_rdy) ir_d = ins_rd_data;
         EXEC: begin
            if (!is_halt) begin
               if (dec.op == OP_LW) begin
                  dat_rd_req_d = 1'b1;
                  dat_addr_d   = ea;
               end else if (dec.op == OP_SW) begin
                  dat_wr_req_d = 1'b1;
                  dat_addr_d   = ea;
                  dat_wdata_d  = rd_val;
               end else begin
                  rf_we = exec_we;
                  pc_d  = exec_pc;
               end
            end
         end
         LWAIT: begin
            if (dat_rd_rdy) begin
               rf_we    = 1'b1;
               rf_wdata = dat_rd_data;
               pc_d     = pc_inc;
            end
         end
         SWAIT: if (dat_wr_rdy) pc_d = pc_inc;
         default: ;
      endcase
   end

   // Datapath registers; reset drops any transaction in flight.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q         <= '0;
         ir_q         <= '0;
         dat_addr_q   <= '0;
         dat_wdata_q  <= '0;
         dat_rd_req_q <= 1'b0;
         dat_wr_req_q <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         ir_q         <= ir_d;
         dat_addr_q   <= dat_addr_d;
         dat_wdata_q  <= dat_wdata_d;
         dat_rd_req_q <= dat_rd_req_d;
         dat_wr_req_q <= dat_wr_req_d;
      end
   end

   // Requests are forced low for as long as reset is held.
   assign ins_rd_addr = pc_q;
   assign ins_rd_req  = fetch_req & reset;
   assign dat_rd_req  = dat_rd_req_q & reset;
   assign dat_wr_req  = dat_wr_req_q & reset;
   assign dat_rw_addr = dat_addr_q;
   assign dat_wr_data = dat_wdata_q;

endmodule

// File: tb/tb_cpu_16.sv
// Self-checking bench for cpu_16: directed programs plus random programs, all
// checked against an instruction-level reference interpreter.
module tb_cpu_16;
   import cpu_16_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] ins_rd_addr;
   logic [15:0] ins_rd_data = '0;
   logic        ins_rd_req;
   logic        ins_rd_rdy  = 1'b0;
   logic [15:0] dat_rw_addr;
   logic [15:0] dat_rd_data = '0;
   logic        dat_rd_req;
   logic        dat_rd_rdy  = 1'b0;
   logic [15:0] dat_wr_data;
   logic        dat_wr_req;
   logic        dat_wr_rdy  = 1'b0;

   cpu_16 dut (
      .clk         (clk),
      .reset       (reset),
      .ins_rd_addr (ins_rd_addr),
      .ins_rd_data (ins_rd_data),
      .ins_rd_req  (ins_rd_req),
      .ins_rd_rdy  (ins_rd_rdy),
      .dat_rw_addr (dat_rw_addr),
      .dat_rd_data (dat_rd_data),
      .dat_rd_req  (dat_rd_req),
      .dat_rd_rdy  (dat_rd_rdy),
      .dat_wr_data (dat_wr_data),
      .dat_wr_req  (dat_wr_req),
      .dat_wr_rdy  (dat_wr_rdy)
   );

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_err    = 0;
   logic [15:0] imem [0:1023];
   int          wp;
   logic [15:0] d_mem [logic [15:0]];
   logic [15:0] m_mem [logic [15:0]];
   logic [31:0] exp_q [$];
   logic [15:0] exp_r [0:7];
   logic [15:0] exp_pc;
   int          exp_cycles, exp_fetches;
   int          cyc_cnt = 0, fetch_cnt = 0, watch_cnt = 0;
   logic [15:0] watch_addr = 16'hFFFF;
   int          i_stall = 0;
   logic [15:0] last_st_addr = '0, last_st_data = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- helpers ----------------
   function automatic logic [15:0] imem_rd(input logic [15:0] a);
      return (a < 16'd1024) ? imem[a[9:0]] : 16'hFFFF;
   endfunction
   function automatic logic [15:0] dflt(input logic [15:0] a);
      return a ^ 16'hC3A5;
   endfunction
   function automatic logic [15:0] sx6(input logic [15:0] w);
      return {{10{w[5]}}, w[5:0]};
   endfunction
   function automatic logic [15:0] sx9(input logic [15:0] w);
      return {{7{w[8]}}, w[8:0]};
   endfunction
   function automatic logic [15:0] sx12(input logic [15:0] w);
      return {{4{w[11]}}, w[11:0]};
   endfunction
   function automatic logic [15:0] i_alu(input int rd, input int ra, input int rb, input int fn);
      return {4'h0, 3'(rd), 3'(ra), 3'(rb), 3'(fn)};
   endfunction
   function automatic logic [15:0] i_ri(input int op, input int rd, input int ra, input int imm);
      return {4'(op), 3'(rd), 3'(ra), 6'(imm)};
   endfunction
   function automatic logic [15:0] i_r9(input int op, input int rd, input int imm);
      return {4'(op), 3'(rd), 9'(imm)};
   endfunction
   function automatic logic [15:0] i_mhi(input int rd, input int byte_v);
      return {4'h3, 3'(rd), 1'b0, 8'(byte_v)};
   endfunction

   task automatic clear_prog(input bit rand_prefix);
      for (int i = 0; i < 1024; i++) imem[i] = 16'hFFFF;
      wp = 0;
      for (int i = 0; i < 8; i++) begin
         imem[wp] = i_r9(2, i, rand_prefix ? int'($urandom_range(0, 511)) : 0);
         wp++;
      end
   endtask

   task automatic put(input logic [15:0] insn);
      imem[wp] = insn;
      wp++;
   endtask

   // Arithmetic definition of the ALU, independent of shift operators.
   function automatic logic [15:0] ref_alu(input logic [2:0] fn, input logic [15:0] a, input logic [15:0] b);
      int s;
      int p;
      s = int'(b[3:0]);
      p = 1 << s;
      case (fn)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return 16'(int'(a) * p);
         3'd6: return 16'(int'(a) / p);
         default: return 16'(int'(a ^ 16'h8000) / p) - 16'(32768 / p);
      endcase
   endfunction

   // Instruction-level interpreter: expected registers, stores, cycles, fetches.
   task automatic run_model();
      logic [15:0] r [0:7];
      logic [15:0] pc, ir, a, b, d, ea;
      bit          done;
      done = 0;
      m_mem.delete();
      exp_q.delete();
      exp_cycles  = 0;
      exp_fetches = 0;
      for (int i = 0; i < 8; i++) r[i] = '0;
      pc = '0;
      for (int step = 0; step < 3000 && !done; step++) begin
         ir = imem_rd(pc);
         exp_fetches++;
         exp_cycles += 3;
         a  = r[ir[8:6]];
         b  = r[ir[5:3]];
         d  = r[ir[11:9]];
         ea = a + sx6(ir);
         if (ir == 16'hFFFF) begin
            done = 1;
         end else begin
            case (ir[15:12])
               4'h0: r[ir[11:9]] = ref_alu(ir[2:0], a, b);
               4'h1: r[ir[11:9]] = a + sx6(ir);
               4'h2: r[ir[11:9]] = sx9(ir);
               4'h3: r[ir[11:9]] = {ir[7:0], d[7:0]};
               4'h4: begin
                  r[ir[11:9]] = m_mem.exists(ea) ? m_mem[ea] : dflt(ea);
                  exp_cycles += 2;
               end
               4'h5: begin
                  m_mem[ea] = d;
                  exp_q.push_back({ea, d});
                  exp_cycles += 2;
               end
               default: ;
            endcase
            case (ir[15:12])
               4'h6:    pc = pc + 16'd1 + ((d == 16'd0) ? sx9(ir) : 16'd0);
               4'h7:    pc = pc + 16'd1 + ((d != 16'd0) ? sx9(ir) : 16'd0);
               4'h8:    pc = pc + 16'd1 + sx12(ir);
               4'h9:    pc = a;
               default: pc = pc + 16'd1;
            endcase
         end
      end
      exp_pc = pc;
      for (int i = 0; i < 8; i++) exp_r[i] = r[i];
   endtask

   // ---------------- instruction memory responder ----------------
   logic        i_busy = 1'b0;
   logic [15:0] i_addr = '0;
   int          i_delay = 0;
   always @(negedge clk) begin
      if (reset && ins_rd_req) begin
         fetch_cnt++;
         if (ins_rd_addr == watch_addr) watch_cnt++;
         i_busy  = 1'b1;
         i_addr  = ins_rd_addr;
         i_delay = i_stall;
      end
   end
   always @(posedge clk) begin
      #1;
      ins_rd_rdy = 1'b0;
      if (!reset) begin
         i_busy = 1'b0;
      end else if (i_busy) begin
         if (i_delay == 0) begin
            ins_rd_rdy  = 1'b1;
            ins_rd_data = imem_rd(i_addr);
            i_busy      = 1'b0;
         end else begin
            i_delay--;
         end
      end
   end

   // ---------------- data memory responder ----------------
   logic        d_busy = 1'b0, d_wr = 1'b0;
   logic [15:0] d_addr = '0, d_wdata = '0;
   logic [31:0] d_exp;
   always @(negedge clk) begin
      if (reset && (dat_rd_rdy || dat_wr_rdy)) begin
         chk("dat_addr_stable", dat_rw_addr, d_addr);
         if (dat_wr_rdy) chk("dat_wdata_stable", dat_wr_data, d_wdata);
      end
      if (reset && (dat_rd_req || dat_wr_req)) begin
         d_busy  = 1'b1;
         d_wr    = dat_wr_req;
         d_addr  = dat_rw_addr;
         d_wdata = dat_wr_data;
         if (dat_wr_req) begin
            last_st_addr = dat_rw_addr;
            last_st_data = dat_wr_data;
            chk("store_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               d_exp = exp_q.pop_front();
               chk("store_addr", dat_rw_addr, d_exp[31:16]);
               chk("store_data", dat_wr_data, d_exp[15:0]);
            end
         end
      end
   end
   always @(posedge clk) begin
      #1;
      dat_rd_rdy = 1'b0;
      dat_wr_rdy = 1'b0;
      if (!reset) begin
         d_busy = 1'b0;
      end else if (d_busy) begin
         if (d_wr) begin
            d_mem[d_addr] = d_wdata;
            dat_wr_rdy    = 1'b1;
         end else begin
            dat_rd_rdy  = 1'b1;
            dat_rd_data = d_mem.exists(d_addr) ? d_mem[d_addr] : dflt(d_addr);
         end
         d_busy = 1'b0;
      end
   end

   // Cycles spent out of reset and not halted.
   always @(negedge clk) begin
      if (reset && dut.state_q != HALT) cyc_cnt++;
   end

   // ---------------- driver tasks ----------------
   task automatic wait_halt(input string name);
      for (int k = 0; k < 5000 && dut.state_q != HALT; k++) @(negedge clk);
      chk($sformatf("%s_halted", name), 32'(dut.state_q), 32'(HALT));
   endtask

   task automatic run_prog(input string name, input int stall);
      int fc;
      d_mem.delete();
      run_model();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      chk($sformatf("%s_rst_pc", name), dut.pc_q, 16'h0000);
      chk($sformatf("%s_rst_ir", name), dut.ir_q, 16'h0000);
      chk($sformatf("%s_rst_state", name), 32'(dut.state_q), 32'(FETCH));
      chk($sformatf("%s_rst_reqs", name), {ins_rd_req, dat_rd_req, dat_wr_req}, 3'b000);
      cyc_cnt   = 0;
      fetch_cnt = 0;
      watch_cnt = 0;
      i_stall   = stall;
      @(posedge clk);
      #2 reset = 1'b1;
      if (stall > 0) begin
         repeat (9) @(negedge clk);
         chk("stall_state", 32'(dut.state_q), 32'(FWAIT));
         chk("stall_addr", ins_rd_addr, 16'h0000);
         chk("stall_one_req", fetch_cnt, 1);
         i_stall = 0;
      end
      wait_halt(name);
      for (int i = 0; i < 8; i++) chk($sformatf("%s_r%0d", name, i), dut.regs.rmem[i], exp_r[i]);
      chk($sformatf("%s_pc", name), dut.pc_q, exp_pc);
      chk($sformatf("%s_fetches", name), fetch_cnt, exp_fetches);
      if (stall == 0) chk($sformatf("%s_cycles", name), cyc_cnt, exp_cycles);
      chk($sformatf("%s_stores_left", name), exp_q.size(), 0);
      fc = fetch_cnt;
      repeat (5) @(negedge clk);
      chk($sformatf("%s_halt_quiet", name), fetch_cnt + int'(dat_rd_req) + int'(dat_wr_req), fc);
      chk($sformatf("%s_halt_pc", name), dut.pc_q, exp_pc);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      // MOVI / ADD
      clear_prog(0);
      put(i_r9(2, 1, 5));
      put(i_r9(2, 2, -3));
      put(i_alu(3, 1, 2, 0));
      run_prog("addmov", 0);
      chk("addmov_r1", dut.regs.rmem[1], 16'h0005);
      chk("addmov_r2", dut.regs.rmem[2], 16'hFFFD);
      chk("addmov_r3", dut.regs.rmem[3], 16'h0002);

      // MHI and arithmetic shift right
      clear_prog(0);
      put(i_r9(2, 1, 16'h12));
      put(i_mhi(1, 16'hAB));
      put(i_r9(2, 5, 4));
      put(i_alu(4, 1, 5, 7));
      run_prog("mhisra", 0);
      chk("mhisra_r1", dut.regs.rmem[1], 16'hAB12);
      chk("mhisra_r4", dut.regs.rmem[4], 16'hFAB1);

      // store then load the same word
      clear_prog(0);
      put(i_r9(2, 1, 16'hAB));
      put(i_ri(5, 1, 0, 2));
      put(i_ri(4, 6, 0, 2));
      run_prog("swlw", 0);
      chk("swlw_st_addr", last_st_addr, 16'h0002);
      chk("swlw_st_data", last_st_data, 16'h00AB);
      chk("swlw_r6", dut.regs.rmem[6], 16'h00AB);

      // countdown loop: body at address 9 runs three times
      clear_prog(0);
      put(i_r9(2, 1, 3));
      put(i_ri(1, 1, 1, -1));
      put(i_r9(7, 1, -2));
      watch_addr = 16'd9;
      run_prog("loop", 0);
      chk("loop_r1", dut.regs.rmem[1], 16'h0000);
      chk("loop_iters", watch_cnt, 3);
      watch_addr = 16'hFFFF;

      // JR skips one instruction
      clear_prog(0);
      put(i_r9(2, 7, 11));
      put(i_ri(9, 0, 7, 0));
      put(i_r9(2, 1, 1));
      put(i_r9(2, 2, 7));
      run_prog("jr", 0);
      chk("jr_r1", dut.regs.rmem[1], 16'h0000);
      chk("jr_r2", dut.regs.rmem[2], 16'h0007);

      // first fetch stalled for ten cycles
      clear_prog(0);
      put(i_r9(2, 1, 5));
      put(i_r9(2, 2, -3));
      put(i_alu(3, 1, 2, 0));
      run_prog("stall", 10);

      // reset asserted while a load is outstanding
      clear_prog(0);
      put(i_ri(4, 3, 0, 5));
      d_mem.delete();
      run_model();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      for (int k = 0; k < 200 && dut.state_q != LWAIT; k++) @(negedge clk);
      chk("rstlw_in_lwait", 32'(dut.state_q), 32'(LWAIT));
      #1 reset = 1'b0;
      @(posedge clk);
      #3;
      chk("rstlw_reqs", {ins_rd_req, dat_rd_req, dat_wr_req}, 3'b000);
      chk("rstlw_pc", dut.pc_q, 16'h0000);
      chk("rstlw_state", 32'(dut.state_q), 32'(FETCH));
      @(posedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      chk("rstlw_refetch_req", ins_rd_req, 1'b1);
      chk("rstlw_refetch_addr", ins_rd_addr, 16'h0000);
      wait_halt("rstlw");
      chk("rstlw_r3", dut.regs.rmem[3], 16'hC3A0);

      // random programs, forward control flow only
      for (int p = 0; p < 6; p++) begin
         logic [15:0] w;
         clear_prog(1);
         for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 9))
               0, 1: w = i_alu($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
               2:    w = i_ri(1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 63));
               3:    w = i_r9(2, $urandom_range(0, 7), $urandom_range(0, 511));
               4:    w = i_mhi($urandom_range(0, 7), $urandom_range(0, 255));
               5:    w = i_ri(4, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 63));
               6:    w = i_ri(5, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 63));
               7:    w = i_r9($urandom_range(6, 7), $urandom_range(0, 7), $urandom_range(0, 3));
               8:    w = {4'h8, 12'($urandom_range(0, 3))};
               default: begin
                  w = {4'($urandom_range(10, 15)), 12'($urandom_range(0, 4095))};
                  if (w == 16'hFFFF) w = 16'hA000;
               end
            endcase
            put(w);
         end
         run_prog($sformatf("rand%0d", p), 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/cpu_16.md
CPU_16 -- requirements
Module: cpu_16

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-low reset (0 = reset).
REQ-004 ins_rd_addr  output  16  instruction word address (= pc).
REQ-005 ins_rd_data  input  16  fetched instruction word.
REQ-006 ins_rd_req  output  1  instruction fetch request pulse.
REQ-007 ins_rd_rdy  input  1  fetch complete; ins_rd_data valid this cycle.
REQ-008 dat_rw_addr  output  16  data word address for load/store.
REQ-009 dat_rd_data  input  16  load data, valid when dat_rd_rdy=1.
REQ-010 dat_rd_req / dat_rd_rdy  output/input  1  load request pulse / load complete.
REQ-011 dat_wr_data  output  16  store data.
REQ-012 dat_wr_req / dat_wr_rdy  output/input  1  store request pulse / store complete.

Function
REQ-013 Fields SHALL be: op=ir[15:12], rd=ir[11:9], ra=ir[8:6], rb=ir[5:3], fn=ir[2:0], imm6=sext(ir[5:0]), imm9=sext(ir[8:0]), imm12=sext(ir[11:0]); all arithmetic is 16-bit and wraps modulo 2^16.
REQ-014 op 0 (ALU): rd = ra fn rb, with fn 0..7 = ADD, SUB, AND, OR, XOR, SLL, SRL, SRA; shift amount = rb[3:0].
REQ-015 op 1 ADDI: rd = ra + imm6; op 2 MOVI: rd = imm9; op 3 MHI: rd[15:8] = ir[7:0], with rd[7:0] unchanged.
REQ-016 op 4 LW: rd = mem[ra + imm6]; op 5 SW: mem[ra + imm6] = rd.
REQ-017 op 6 BZ / op 7 BNZ: if rd==0 (or !=0 for BNZ), pc = pc + 1 + imm9; otherwise pc = pc + 1.
REQ-018 op 8 B: pc = pc + 1 + imm12; op 9 JR: pc = ra; ops A-F (except HALT): no operation, pc = pc + 1.
REQ-019 ir == 16'hFFFF SHALL be HALT: the block enters HALT, issues no further requests and holds all state until reset.
REQ-020 The FSM SHALL have the states FETCH, FWAIT, EXEC, LWAIT, SWAIT and HALT.
REQ-021 FETCH SHALL assert ins_rd_req for exactly one cycle, then go to FWAIT.
REQ-022 FWAIT SHALL wait for ins_rd_rdy, then latch ir = ins_rd_data and go to EXEC.
REQ-023 EXEC SHALL perform write-back and pc update, then go to FETCH, except: LW pulses dat_rd_req and goes to LWAIT; SW pulses dat_wr_req and goes to SWAIT; HALT goes to HALT.
REQ-024 LWAIT SHALL wait for dat_rd_rdy, write dat_rd_data to rd, advance pc and go to FETCH.
REQ-025 SWAIT SHALL wait for dat_wr_rdy, advance pc and go to FETCH.
REQ-026 Each req SHALL be a single-cycle pulse; the matching address (and write data) SHALL stay stable from the pulse until rdy is sampled.
REQ-027 rdy SHALL be ignored in every state except its own wait state.
REQ-028 With 1-cycle memory, CPI SHALL be 3 for non-memory instructions and 5 for LW/SW.
REQ-029 Register reads SHALL be combinational; the register file SHALL accept at most one write per cycle, at the clock edge.

Reset
REQ-030 While reset=0: pc=0, ir=0, state=FETCH, and all req outputs = 0.
REQ-031 Reset asserted mid-transaction SHALL abandon that transaction; the first fetch after reset is from address 0.
REQ-032 Register file contents SHALL NOT be reset.

Structure
REQ-033 A shared package SHALL hold the opcode constants, ALU fn constants, FSM state enum and HALT_INSN=16'hFFFF.
REQ-034 The register file SHALL be one sub-module, regfile, instantiated as "regs", storing rmem[0:7] of 16 bits.
REQ-035 The ir register SHALL be a named register visible hierarchically to the bench.
REQ-036 Memories are external single-port word RAMs with registered read; the bench generates rdy = req delayed by one cycle.

Verification
REQ-037 MOVI r1,5; MOVI r2,-3; ADD r3,r1,r2; HALT -> r1=0005, r2=FFFD, r3=0002.
REQ-038 MOVI r1,0x12; MHI r1,0xAB; SRA r4,r1,r5 with r5=4 -> r1=AB12, r4=FAB1.
REQ-039 SW r1,[r0+2] then LW r6,[r0+2] -> dat_wr_req pulses with addr 0002, data = r1; after the load, r6 = r1.
REQ-040 MOVI r1,3; loop ADDI r1,r1,-1; BNZ r1,-2; HALT -> r1=0000 and exactly 3 loop iterations.
REQ-041 ins_rd_rdy held low for 10 cycles -> CPU stalls in FWAIT, ins_rd_addr stable, no second req pulse.
REQ-042 Reset=0 asserted during LWAIT -> next cycle all reqs are 0; after release, first fetch is from address 0.
